// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding, default widths and divide-by-zero result fill
package divider_pkg;
    localparam int W_DEF     = 64;
    localparam int CNT_W_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Divide-by-zero quotient is this bit replicated across the word (all ones, -1)
    localparam logic DBZ_Q_FILL = 1'b1;
endpackage

// File: rtl/divider_if.sv
// divider_if: operand/result bus with the op_start/op_clear/op_done handshake
interface divider_if #(
    parameter int W = 64
);
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         op_start;
    logic         op_clear;
    logic         op_done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output dividend, divisor, op_start, op_clear,
        input  op_done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  dividend, divisor, op_start, op_clear,
        output op_done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_step.sv
// divider_step: one radix-2 restoring iteration on unsigned magnitudes
module divider_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem_i,
    input  logic         quo_msb_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic         q_bit_o
);
    logic [W:0] sh;

    // The shifted remainder needs W+1 bits for the compare; the difference always fits in W
    always_comb begin
        sh      = {rem_i, quo_msb_i};
        q_bit_o = sh >= {1'b0, dvs_i};
        rem_o   = q_bit_o ? sh[W-1:0] - dvs_i : sh[W-1:0];
    end
endmodule

// File: rtl/divider.sv
// divider: sequential signed W-bit restoring divider, one quotient bit per cycle
module divider
    import divider_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic     clk,
    input  logic     reset,
    divider_if.slave bus
);
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     rem_q, quo_q, dvs_q;
    logic [W-1:0]     quotient_q, remainder_q;
    logic             sdvd_q, sdvs_q, dbz_q;
    logic             done_q, dbz_out_q;
    logic [W-1:0]     rem_d;
    logic             q_bit_d;

    divider_step #(.W(W)) u_step (
        .rem_i     (rem_q),
        .quo_msb_i (quo_q[W-1]),
        .dvs_i     (dvs_q),
        .rem_o     (rem_d),
        .q_bit_o   (q_bit_d)
    );

    // quo_q starts as |dividend| and shifts out its MSB into the remainder each step
    always_ff @(posedge clk) begin
        if (reset || bus.op_clear) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_out_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.op_start) begin
                    quo_q   <= bus.dividend[W-1] ? -bus.dividend : bus.dividend;
                    dvs_q   <= bus.divisor[W-1] ? -bus.divisor : bus.divisor;
                    sdvd_q  <= bus.dividend[W-1];
                    sdvs_q  <= bus.divisor[W-1];
                    dbz_q   <= bus.divisor == '0;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W)) begin
                        state_q <= ST_FIX;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= {quo_q[W-2:0], q_bit_d};
                    end
                end
                ST_FIX: begin
                    quotient_q  <= dbz_q ? {W{DBZ_Q_FILL}} : (sdvd_q ^ sdvs_q) ? -quo_q : quo_q;
                    remainder_q <= sdvd_q ? -rem_q : rem_q;
                    dbz_out_q   <= dbz_q;
                    done_q      <= 1'b1;
                    state_q     <= ST_DONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.op_done     = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_out_q;
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed table, corner sequences and random checks against a signed-arithmetic model
module tb_divider;
    localparam int W = 64;
    localparam logic [W-1:0] MIN = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         z;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    divider_if #(.W(W)) bus ();

    divider #(.W(W), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    function automatic void model(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else if (a == MIN && b == '1) begin
            q = a;
            r = '0;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.op_done && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit clr_after,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                           output int lat);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.op_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.op_start = 1'b0;
        bus.dividend = {$urandom(), $urandom()};
        bus.divisor  = {$urandom(), $urandom()};
        wait_done(lat);
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
        if (clr_after) begin
            bus.op_clear = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.op_clear = 1'b0;
        end
    endtask

    initial begin
        vec_t         v[9];
        logic [W-1:0] q, r, eq, er, a, b;
        logic         z, ez, seen;
        int           lat;

        v[0] = '{64'd15, 64'd3, 64'd5, 64'd0, 1'b0};
        v[1] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'd4, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        v[2] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0};
        v[3] = '{64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1};
        v[4] = '{MIN, 64'hFFFF_FFFF_FFFF_FFFF, MIN, 64'd0, 1'b0};
        v[5] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1};
        v[6] = '{MIN, 64'd1, MIN, 64'd0, 1'b0};
        v[7] = '{64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        v[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0};

        bus.dividend = '0;
        bus.divisor  = '0;
        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_done", 64'(bus.op_done), 64'd0);
        chk("reset_q", bus.quotient, 64'd0);
        chk("reset_r", bus.remainder, 64'd0);
        chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_div(v[i].a, v[i].b, 1'b1, q, r, z, lat);
            chk($sformatf("vec%0d_q", i), q, v[i].q);
            chk($sformatf("vec%0d_r", i), r, v[i].r);
            chk($sformatf("vec%0d_dbz", i), 64'(z), 64'(v[i].z));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd66);
        end

        run_div(64'd15, 64'd3, 1'b0, q, r, z, lat);
        bus.op_start = 1'b1;
        bus.dividend = 64'd100;
        bus.divisor  = 64'd7;
        repeat (5) @(negedge clk);
        chk("hold_done", 64'(bus.op_done), 64'd1);
        chk("hold_q", bus.quotient, 64'd5);
        bus.op_start = 1'b0;
        bus.op_clear = 1'b1;
        @(negedge clk);
        bus.op_clear = 1'b0;
        chk("clr_done", 64'(bus.op_done), 64'd0);
        chk("clr_q", bus.quotient, 64'd0);

        bus.dividend = 64'd15;
        bus.divisor  = 64'd3;
        bus.op_start = 1'b1;
        repeat (30) @(negedge clk);
        bus.op_clear = 1'b1;
        @(negedge clk);
        chk("abort_done", 64'(bus.op_done), 64'd0);
        chk("abort_q", bus.quotient, 64'd0);
        chk("abort_r", bus.remainder, 64'd0);
        bus.op_clear = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.op_start = 1'b0;
        wait_done(lat);
        chk("restart_lat", 64'(lat), 64'd66);
        chk("restart_q", bus.quotient, 64'd5);
        bus.op_clear = 1'b1;
        @(negedge clk);

        bus.op_start = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            seen |= bus.op_done;
        end
        chk("start_clear_idle", 64'(seen), 64'd0);
        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;

        for (int i = 0; i < 24; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = $urandom_range(0, 1) ? 64'($urandom_range(1, 20)) : -64'($urandom_range(1, 20));
                2: begin b = '1; if ($urandom_range(0, 1) == 1) a = MIN; end
                3: a = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            model(a, b, eq, er, ez);
            run_div(a, b, 1'b1, q, r, z, lat);
            chk($sformatf("rnd%0d_q", i), q, eq);
            chk($sformatf("rnd%0d_r", i), r, er);
            chk($sformatf("rnd%0d_dbz", i), 64'(z), 64'(ez));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
